// File: rtl/vga_pkg.sv
// Shared types, widths and the pixel-to-RGB colour mapping for the
// VGA pixel fetch stage.
package vga_pkg;

    localparam int FB_AW = 16;
    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        PM_GREY,
        PM_RGB332,
        PM_BARS,
        PM_BORDER
    } pix_mode_t;

    typedef enum logic {
        WAIT_FRAME,
        RUN
    } fetch_state_t;

    // Returns {red, green, blue}. hact/vact give the active window
    // size, used for the border position.
    function automatic logic [23:0] rgb_from_pixel(
        input pix_mode_t        mode,
        input logic [PIX_W-1:0] d,
        input logic [9:0]       xd,
        input logic [9:0]       yd,
        input logic [9:0]       hact = 10'd256,
        input logic [9:0]       vact = 10'd256
    );
        logic [23:0] rgb;
        logic [2:0]  k;
        rgb = '0;
        k   = xd[7:5];
        case (mode)
            PM_GREY: rgb = {d, d, d};
            PM_RGB332: begin
                rgb = {d[7:5], d[7:5], d[7:6],
                       d[4:2], d[4:2], d[4:3],
                       {4{d[1:0]}}};
            end
            PM_BARS: begin
                rgb = {{8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
            end
            PM_BORDER: begin
                if (xd == 10'd0 || xd == hact - 10'd1 ||
                    yd == 10'd0 || yd == vact - 10'd1)
                    rgb = '1;
            end
            default: rgb = '0;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous reset value.
// Ports: i_clk, i_rst (sync, active high), i_d in, o_q delayed by DEPTH.
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_pipe[i] <= RST_VAL;
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++)
                r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// VGA pixel fetch: issues framebuffer reads for the active window and
// turns returned pixels or a test pattern into aligned RGB + syncs.
// Ports: vga_clk/rst; raster in (x_in, y_in, syncs, blank_b_in, mode);
// framebuffer (mem_addr, mem_rd_en, mem_rdata); delayed syncs, blank_b,
// red/green/blue, frame_count.
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter logic [9:0] HACTIVE = 10'd256,
    parameter logic [9:0] VACTIVE = 10'd256,
    parameter int         MEM_LAT = 1
) (
    input  logic             vga_clk,
    input  logic             rst,
    input  logic [9:0]       x_in,
    input  logic [9:0]       y_in,
    input  logic             h_sync_in,
    input  logic             v_sync_in,
    input  logic             blank_b_in,
    input  logic [1:0]       mode,
    output logic [FB_AW-1:0] mem_addr,
    output logic             mem_rd_en,
    input  logic [PIX_W-1:0] mem_rdata,
    output logic             h_sync,
    output logic             v_sync,
    output logic             sync_b,
    output logic             blank_b,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue,
    output logic [15:0]      frame_count
);

    localparam int PW = 23;
    localparam logic [PW-1:0] PIPE_RST =
        {1'b1, 1'b1, 1'b0, 10'd0, 10'd0};

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    pix_mode_t    r_mode_q;
    logic         r_vs_in_q;
    logic [15:0]  r_frame_count;

    logic         r_h_sync;
    logic         r_v_sync;
    logic         r_sync_b;
    logic         r_blank_b;
    logic [7:0]   r_red;
    logic [7:0]   r_green;
    logic [7:0]   r_blue;

    logic [PW-1:0] w_pipe_in;
    logic [PW-1:0] w_pipe_out;
    logic          w_hs_d;
    logic          w_vs_d;
    logic          w_bl_d;
    logic [9:0]    w_xd;
    logic [9:0]    w_yd;
    logic          w_v_fall;
    logic          w_vis;
    logic [23:0]   w_rgb;

    assign w_v_fall = r_vs_in_q & ~v_sync_in;

    assign mem_addr  = {y_in[7:0], x_in[7:0]};
    assign mem_rd_en = blank_b_in & ~r_mode_q[1]
                     & (r_state == RUN);

    // Raster info travels MEM_LAT stages so it meets the read data.
    assign w_pipe_in = {h_sync_in, v_sync_in, blank_b_in,
                        x_in, y_in};

    vga_delay_line #(
        .WIDTH   (PW),
        .DEPTH   (MEM_LAT),
        .RST_VAL (PIPE_RST)
    ) u_dly (
        .i_clk (vga_clk),
        .i_rst (rst),
        .i_d   (w_pipe_in),
        .o_q   (w_pipe_out)
    );

    assign w_hs_d = w_pipe_out[22];
    assign w_vs_d = w_pipe_out[21];
    assign w_bl_d = w_pipe_out[20];
    assign w_xd   = w_pipe_out[19:10];
    assign w_yd   = w_pipe_out[9:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT_FRAME: if (w_v_fall) w_state_nxt = RUN;
            RUN:        w_state_nxt = RUN;
            default:    w_state_nxt = WAIT_FRAME;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (rst) r_state <= WAIT_FRAME;
        else     r_state <= w_state_nxt;
    end

    // Mode and frame counter only move on a vsync falling edge so a
    // frame is always rendered in one consistent mode.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_vs_in_q     <= 1'b1;
            r_mode_q      <= PM_GREY;
            r_frame_count <= '0;
        end else begin
            r_vs_in_q <= v_sync_in;
            if (w_v_fall) begin
                r_mode_q      <= pix_mode_t'(mode);
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign w_vis = w_bl_d & (r_state == RUN);
    assign w_rgb = rgb_from_pixel(r_mode_q, mem_rdata,
                                  w_xd, w_yd,
                                  HACTIVE, VACTIVE);

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_h_sync  <= 1'b1;
            r_v_sync  <= 1'b1;
            r_sync_b  <= 1'b1;
            r_blank_b <= 1'b0;
            r_red     <= '0;
            r_green   <= '0;
            r_blue    <= '0;
        end else begin
            r_h_sync  <= w_hs_d;
            r_v_sync  <= w_vs_d;
            r_sync_b  <= w_hs_d & w_vs_d;
            r_blank_b <= w_vis;
            r_red     <= w_vis ? w_rgb[23:16] : 8'd0;
            r_green   <= w_vis ? w_rgb[15:8]  : 8'd0;
            r_blue    <= w_vis ? w_rgb[7:0]   : 8'd0;
        end
    end

    assign h_sync      = r_h_sync;
    assign v_sync      = r_v_sync;
    assign sync_b      = r_sync_b;
    assign blank_b     = r_blank_b;
    assign red         = r_red;
    assign green       = r_green;
    assign blue        = r_blue;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Testbench for vga_pixel_fetch: scenario tasks drive raster stimulus
// and compare against a frame-level reference model.
module tb_vga_pixel_fetch;
    import vga_pkg::*;

    logic        vga_clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  x_in = '0;
    logic [9:0]  y_in = '0;
    logic        h_sync_in = 1'b1;
    logic        v_sync_in = 1'b1;
    logic        blank_b_in = 1'b0;
    logic [1:0]  mode = '0;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_rdata = '0;
    logic        h_sync, v_sync, sync_b, blank_b;
    logic [7:0]  red, green, blue;
    logic [15:0] frame_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [65536];

    // Model state
    logic        m_run = 1'b0;
    logic [1:0]  m_mode = '0;
    logic [15:0] m_cnt = '0;
    logic        m_vprev = 1'b1;
    logic        p_h = 1'b1, p_v = 1'b1, p_b = 1'b0;
    logic [23:0] p_rgb = '0;

    vga_pixel_fetch #(
        .HACTIVE (10'd256),
        .VACTIVE (10'd256),
        .MEM_LAT (1)
    ) dut (
        .vga_clk     (vga_clk),
        .rst         (rst),
        .x_in        (x_in),
        .y_in        (y_in),
        .h_sync_in   (h_sync_in),
        .v_sync_in   (v_sync_in),
        .blank_b_in  (blank_b_in),
        .mode        (mode),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rdata   (mem_rdata),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .sync_b      (sync_b),
        .blank_b     (blank_b),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .frame_count (frame_count)
    );

    always #5 vga_clk = ~vga_clk;

    // One-cycle-latency RAM; garbage when no read is issued.
    always @(posedge vga_clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        else           mem_rdata <= 8'($urandom);
    end

    function automatic logic [23:0] model_rgb(
        input logic [1:0] md, input logic [7:0] d,
        input int x, input int y);
        int k;
        logic [7:0] r, g, b;
        case (md)
            2'd0: return {d, d, d};
            2'd1: return {d[7:5], d[7:5], d[7:6],
                          d[4:2], d[4:2], d[4:3],
                          d[1:0], d[1:0], d[1:0], d[1:0]};
            2'd2: begin
                k = (x % 256) / 32;
                r = (k >= 4) ? 8'hFF : 8'h00;
                g = ((k / 2) % 2 == 1) ? 8'hFF : 8'h00;
                b = (k % 2 == 1) ? 8'hFF : 8'h00;
                return {r, g, b};
            end
            default: begin
                if (x == 0 || x == 255 || y == 0 || y == 255)
                    return 24'hFFFFFF;
                return 24'h000000;
            end
        endcase
    endfunction

    // Drive one pixel at a negedge, step the model across the edge,
    // then check the outputs belonging to the previous pixel.
    task automatic cyc(input int x, input int y, input logic h,
                       input logic v, input logic b,
                       input logic [1:0] md, input logic r);
        logic        vf;
        logic        n_h, n_v, n_b, e_rd;
        logic [23:0] n_rgb;
        logic [15:0] a;
        a = {8'(y), 8'(x)};
        x_in = 10'(x); y_in = 10'(y);
        h_sync_in = h; v_sync_in = v;
        blank_b_in = b; mode = md; rst = r;
        #1;
        if (!r) begin
            e_rd = b & ~m_mode[1] & m_run;
            n_cmp++;
            if (mem_rd_en !== e_rd) begin
                n_bad++;
                $display("FAIL rd_en got %b want %b", mem_rd_en, e_rd);
            end
            n_cmp++;
            if (mem_addr !== a) begin
                n_bad++;
                $display("FAIL addr got %h want %h", mem_addr, a);
            end
        end
        @(posedge vga_clk);
        if (r) begin
            m_run = 0; m_mode = 0; m_cnt = 0; m_vprev = 1;
            n_h = 1; n_v = 1; n_b = 0; n_rgb = 0;
            p_h = 1; p_v = 1; p_b = 0; p_rgb = 0;
        end else begin
            vf = m_vprev & ~v;
            m_vprev = v;
            if (vf) begin
                m_run = 1; m_mode = md; m_cnt = m_cnt + 16'd1;
            end
            n_h = h; n_v = v; n_b = b & m_run;
            n_rgb = n_b ? model_rgb(m_mode, mem[a], x, y) : 24'd0;
        end
        @(negedge vga_clk);
        n_cmp++;
        if ({h_sync, v_sync, sync_b} !== {p_h, p_v, p_h & p_v}) begin
            n_bad++;
            $display("FAIL syncs got %b%b%b want %b%b%b",
                     h_sync, v_sync, sync_b, p_h, p_v, p_h & p_v);
        end
        n_cmp++;
        if (blank_b !== p_b) begin
            n_bad++;
            $display("FAIL blank_b got %b want %b", blank_b, p_b);
        end
        n_cmp++;
        if ({red, green, blue} !== p_rgb) begin
            n_bad++;
            $display("FAIL rgb got %h want %h",
                     {red, green, blue}, p_rgb);
        end
        n_cmp++;
        if (frame_count !== m_cnt) begin
            n_bad++;
            $display("FAIL frame_count got %h want %h",
                     frame_count, m_cnt);
        end
        p_h = n_h; p_v = n_v; p_b = n_b; p_rgb = n_rgb;
    endtask

    task automatic vframe(input logic [1:0] md);
        cyc(300, 270, 1, 1, 0, md, 0);
        cyc(300, 270, 1, 0, 0, md, 0);
        cyc(300, 270, 1, 0, 0, md, 0);
        cyc(300, 271, 1, 1, 0, md, 0);
    endtask

    task automatic rand_pix(input int n, input logic [1:0] md);
        int x, y;
        for (int i = 0; i < n; i++) begin
            x = int'($urandom_range(0, 319));
            y = int'($urandom_range(0, 263));
            cyc(x, y, !(x >= 280 && x < 300), 1,
                (x < 256 && y < 256), md, 0);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0, 0, 1);
        n_cmp++;
        if ({h_sync, v_sync, sync_b, blank_b} !== 4'b1110 ||
            {red, green, blue} !== 24'd0 ||
            frame_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_vals got %b %h %h want 1110 0 0",
                     {h_sync, v_sync, sync_b, blank_b},
                     {red, green, blue}, frame_count);
        end
        rand_pix(40, 0);
        n_cmp++;
        if (dut.r_state !== WAIT_FRAME) begin
            n_bad++;
            $display("FAIL wait_state got %b want %b",
                     dut.r_state, WAIT_FRAME);
        end
    endtask

    task automatic test_grey();
        vframe(0);
        cyc(5, 3, 1, 1, 1, 0, 0);
        cyc(6, 3, 1, 1, 1, 0, 0);
        n_cmp++;
        if ({red, green, blue} !== 24'h060606) begin
            n_bad++;
            $display("FAIL grey_5_3 got %h want 060606",
                     {red, green, blue});
        end
        rand_pix(300, 0);
    endtask

    task automatic test_rgb332();
        mem[16'h1010] = 8'hE3;
        mem[16'h2020] = 8'h1C;
        vframe(1);
        cyc(16, 16, 1, 1, 1, 1, 0);
        cyc(32, 32, 1, 1, 1, 1, 0);
        n_cmp++;
        if ({red, green, blue} !== 24'hFF00FF) begin
            n_bad++;
            $display("FAIL rgb332_E3 got %h want FF00FF",
                     {red, green, blue});
        end
        cyc(40, 40, 1, 1, 1, 1, 0);
        n_cmp++;
        if ({red, green, blue} !== 24'h00FF00) begin
            n_bad++;
            $display("FAIL rgb332_1C got %h want 00FF00",
                     {red, green, blue});
        end
        for (int i = 0; i < 64; i++)
            mem[16'($urandom)] = 8'($urandom);
        rand_pix(300, 1);
    endtask

    task automatic test_bars();
        vframe(2);
        for (int i = 0; i <= 32; i++) begin
            cyc(i, 77, 1, 1, 1, 2, 0);
            if (i > 0) begin
                n_cmp++;
                if ({blank_b, red, green, blue} !== 25'h1000000) begin
                    n_bad++;
                    $display("FAIL bar0 x=%0d got %b %h want 1 000000",
                             i - 1, blank_b, {red, green, blue});
                end
            end
        end
        for (int i = 224; i <= 256; i++) begin
            cyc(i, 90, 1, 1, i < 256, 2, 0);
            if (i > 224) begin
                n_cmp++;
                if ({blank_b, red, green, blue} !== 25'h1FFFFFF) begin
                    n_bad++;
                    $display("FAIL bar7 x=%0d got %b %h want 1 FFFFFF",
                             i - 1, blank_b, {red, green, blue});
                end
            end
        end
        cyc(300, 90, 1, 1, 0, 2, 0);
        n_cmp++;
        if ({blank_b, red, green, blue} !== 25'd0) begin
            n_bad++;
            $display("FAIL bar_offscreen got %b %h want 0 000000",
                     blank_b, {red, green, blue});
        end
        rand_pix(200, 2);
    endtask

    task automatic test_mode_change();
        int bx[5] = '{0, 255, 100, 100, 100};
        int by[5] = '{100, 100, 0, 255, 100};
        logic [23:0] bw[5] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
                               24'hFFFFFF, 24'h000000};
        vframe(0);
        rand_pix(100, 3);
        cyc(5, 3, 1, 1, 1, 3, 0);
        cyc(6, 3, 1, 1, 1, 3, 0);
        n_cmp++;
        if ({red, green, blue} !== 24'h060606) begin
            n_bad++;
            $display("FAIL mode_hold got %h want 060606",
                     {red, green, blue});
        end
        vframe(3);
        for (int i = 0; i < 5; i++) begin
            cyc(bx[i], by[i], 1, 1, 1, 3, 0);
            cyc(300, by[i], 1, 1, 0, 3, 0);
            cyc(300, by[i], 1, 1, 0, 3, 0);
            n_cmp++;
            if ({red, green, blue} !== 24'd0 || blank_b !== 1'b0) begin
                n_bad++;
                $display("FAIL border_blank got %b %h want 0 000000",
                         blank_b, {red, green, blue});
            end
        end
        for (int i = 0; i < 5; i++) begin
            cyc(bx[i], by[i], 1, 1, 1, 3, 0);
            cyc(300, 0, 1, 1, 0, 3, 0);
            n_cmp++;
            if ({red, green, blue} !== bw[i]) begin
                n_bad++;
                $display("FAIL border x=%0d y=%0d got %h want %h",
                         bx[i], by[i], {red, green, blue}, bw[i]);
            end
        end
        rand_pix(200, 3);
    endtask

    task automatic test_wrap();
        logic [15:0] want[3] = '{16'hFFFF, 16'h0000, 16'h0001};
        force dut.r_frame_count = 16'hFFFE;
        #2;
        release dut.r_frame_count;
        m_cnt = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            vframe(0);
            n_cmp++;
            if (frame_count !== want[i]) begin
                n_bad++;
                $display("FAIL wrap%0d got %h want %h",
                         i, frame_count, want[i]);
            end
            rand_pix(20, 0);
        end
    endtask

    task automatic test_reset_mid();
        vframe(1);
        rand_pix(30, 1);
        cyc(100, 50, 1, 1, 1, 1, 1);
        n_cmp++;
        if (dut.r_state !== WAIT_FRAME) begin
            n_bad++;
            $display("FAIL rst_state got %b want %b",
                     dut.r_state, WAIT_FRAME);
        end
        for (int i = 0; i < 40; i++) begin
            cyc(i + 10, 60, 1, 1, 1, 1, 0);
            n_cmp++;
            if (blank_b !== 1'b0 || {red, green, blue} !== 24'd0) begin
                n_bad++;
                $display("FAIL rst_hidden got %b %h want 0 000000",
                         blank_b, {red, green, blue});
            end
        end
        vframe(0);
        cyc(5, 3, 1, 1, 1, 0, 0);
        cyc(6, 3, 1, 1, 1, 0, 0);
        n_cmp++;
        if (blank_b !== 1'b1 || {red, green, blue} !== 24'h060606) begin
            n_bad++;
            $display("FAIL rst_resume got %b %h want 1 060606",
                     blank_b, {red, green, blue});
        end
        rand_pix(100, 0);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            logic [15:0] aa;
            aa = 16'(a);
            mem[a] = aa[7:0] ^ aa[15:8];
        end
        test_reset();
        test_grey();
        test_rgb332();
        test_bars();
        test_mode_change();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
